// File: rtl/rng_request_arbiter.sv
// Round-robin arbiter that shares one LFSR between NUM_REQ requesters and range-limits
// each draw by rejection sampling. Optional LFSR reseed path: define RNG_RESEED_EN.
module rng_request_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 10,
    parameter int MAX_TRIES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] bound,
    output logic [NUM_REQ-1:0]       ack,
    output logic [WIDTH-1:0]         rnd_out,
    output logic                     busy,
    output logic                     lfsr_step,
`ifdef RNG_RESEED_EN
    input  logic                     reseed,
    input  logic [WIDTH-1:0]         seed,
    output logic                     lfsr_load,
    output logic [WIDTH-1:0]         lfsr_seed,
`endif
    input  logic [WIDTH-1:0]         lfsr_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TRY_W = 4;

    typedef enum logic [1:0] {IDLE, DRAW, CHECK, ACK} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] rr_ptr, winner;
    logic [WIDTH-1:0] bound_q, mask_q;
    logic [TRY_W-1:0] tries;

    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_bound, grant_bm1, grant_mask;
    logic [WIDTH-1:0] cand, result_nxt;
    logic             accept, give_up, arb_en;

    // First requester at or after rr_ptr, wrapping: scan downward so the lowest offset wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // Mask is bound-1 with every bit below its MSB filled in; bound 0 draws the full word.
    always_comb begin
        grant_bound = bound[int'(grant_idx)*WIDTH +: WIDTH];
        grant_bm1   = grant_bound - WIDTH'(1);
        grant_mask  = grant_bm1;
        for (int s = 1; s < WIDTH; s++) begin
            grant_mask = grant_mask | (grant_bm1 >> s);
        end
        if (grant_bound == '0) begin
            grant_mask = '1;
        end
    end

    always_comb begin
        cand       = lfsr_data & mask_q;
        accept     = (bound_q == '0) || (cand < bound_q);
        give_up    = (tries == TRY_W'(MAX_TRIES - 1));
        result_nxt = accept ? cand : cand - bound_q;
    end

`ifdef RNG_RESEED_EN
    logic             reseed_pend;
    logic [WIDTH-1:0] seed_pend, seed_sel;
    logic             load_now;

    // A load cycle in IDLE pre-empts arbitration; pending requests are taken the cycle after.
    always_comb begin
        load_now  = (state == IDLE) && (reseed || reseed_pend);
        seed_sel  = reseed ? seed : seed_pend;
        arb_en    = !load_now;
        lfsr_load = load_now;
        lfsr_seed = (seed_sel == '0) ? '1 : seed_sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reseed_pend <= 1'b0;
            seed_pend   <= '0;
        end else if (load_now) begin
            reseed_pend <= 1'b0;
        end else if (reseed) begin
            reseed_pend <= 1'b1;
            seed_pend   <= seed;
        end
    end
`else
    assign arb_en = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block is given a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        lfsr_step = 1'b0;
        case (state)
            IDLE:    if (arb_en && grant_found) state_nxt = DRAW;
            DRAW: begin
                lfsr_step = 1'b1;
                state_nxt = CHECK;
            end
            CHECK:   state_nxt = (accept || give_up) ? ACK : DRAW;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: ack and rnd_out are loaded on the CHECK->ACK edge so both are registered in ACK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack     <= '0;
            rnd_out <= '0;
            rr_ptr  <= '0;
            winner  <= '0;
            bound_q <= '0;
            mask_q  <= '0;
            tries   <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (arb_en && grant_found) begin
                        winner  <= grant_idx;
                        bound_q <= grant_bound;
                        mask_q  <= grant_mask;
                        tries   <= '0;
                    end
                end
                CHECK: begin
                    if (accept || give_up) begin
                        ack     <= NUM_REQ'(1) << winner;
                        rnd_out <= result_nxt;
                    end else begin
                        tries <= tries + TRY_W'(1);
                    end
                end
                ACK:     rr_ptr <= IDX_W'((int'(winner) + 1) % NUM_REQ);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rng_request_arbiter.sv
// Scoreboard bench for rng_request_arbiter: a queue-driven LFSR stand-in, a behavioural
// prediction of grant order, draw count and value, and a separate ack monitor.
module tb_rng_request_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 10;
    localparam int MAX_TRIES = 4;
    localparam int WSZ       = 4096;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] bound;
    logic [NUM_REQ-1:0]       ack;
    logic [WIDTH-1:0]         rnd_out;
    logic                     busy;
    logic                     lfsr_step;
    logic [WIDTH-1:0]         lfsr_data;

    // LFSR stand-in: a word sequence that advances one entry per lfsr_step edge.
    logic [WIDTH-1:0] words [WSZ];
    int               widx = 0;

    typedef struct {
        int idx;
        int val;
        int draws;
    } exp_t;

    exp_t exp_q[$];
    int   model_rr = 0;
    int   rb[NUM_REQ];
    int   rrep[NUM_REQ];
    int   n_checks = 0;
    int   n_pass = 0;
    int   busy_cnt = 0;
    int   step_cnt = 0;

    rng_request_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .WIDTH    (WIDTH),
        .MAX_TRIES(MAX_TRIES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .bound    (bound),
        .ack      (ack),
        .rnd_out  (rnd_out),
        .busy     (busy),
        .lfsr_step(lfsr_step),
        .lfsr_data(lfsr_data)
    );

    always #5 clk = ~clk;

    assign lfsr_data = words[widx % WSZ];

    always @(posedge clk) begin
        if (lfsr_step) widx <= widx + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Value and draw count for bound b when the next draws read words[p+1], words[p+2], ...
    function automatic void predict(input int b, input int p, output int val, output int draws);
        int m;
        int cand;
        if (b == 0) begin
            m = (1 << WIDTH) - 1;
        end else begin
            m = 0;
            while (m < b - 1) m = m * 2 + 1;
        end
        val   = 0;
        draws = MAX_TRIES;
        for (int t = 0; t < MAX_TRIES; t++) begin
            cand = int'(words[(p + 1 + t) % WSZ]) & m;
            if (b == 0 || cand < b) begin
                val   = cand;
                draws = t + 1;
                return;
            end
            if (t == MAX_TRIES - 1) val = cand - b;
        end
    endfunction

    function automatic int rand_bound();
        case ($urandom_range(0, 4))
            0:       return 0;
            1:       return 1;
            2:       return int'($urandom_range(2, (1 << WIDTH) - 1));
            3:       return (1 << $urandom_range(1, 8)) + 1;
            default: return 1 << $urandom_range(1, 9);
        endcase
    endfunction

    // Requester i asks rrep[i] times in a row with bound rb[i]; it drops req after its last ack.
    task automatic run_round(input logic [NUM_REQ-1:0] m);
        int left[NUM_REQ];
        int p, rr, total, budget, v, d, w, last_val;
        p        = widx;
        rr       = model_rr;
        total    = 0;
        last_val = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            left[i] = m[i] ? rrep[i] : 0;
            total  += left[i];
        end
        for (int s = 0; s < total; s++) begin
            w = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (w < 0 && left[(rr + k) % NUM_REQ] > 0) w = (rr + k) % NUM_REQ;
            end
            predict(rb[w], p, v, d);
            exp_q.push_back('{w, v, d});
            p       += d;
            left[w]--;
            rr       = (w + 1) % NUM_REQ;
            last_val = v;
        end
        model_rr = rr;

        for (int i = 0; i < NUM_REQ; i++) begin
            bound[i*WIDTH +: WIDTH] = WIDTH'(rb[i]);
            left[i] = m[i] ? rrep[i] : 0;
        end
        req    = m;
        budget = total * (2 * MAX_TRIES + 2) + 10;
        while (budget > 0 && !(req == '0 && !busy)) begin
            @(negedge clk);
            budget--;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ack[i] && left[i] > 0) begin
                    left[i]--;
                    if (left[i] == 0) req[i] = 1'b0;
                end
            end
        end
        if (budget == 0) begin
            check("round_timeout", 0, 1);
            req = '0;
        end else begin
            check("rnd_out_hold", int'(rnd_out), last_val);
        end
    endtask

    // Monitor: busy-cycle and step counts per service, compared at every ack.
    always @(negedge clk) begin
        if (rst || !busy) begin
            busy_cnt = 0;
            step_cnt = 0;
        end else begin
            busy_cnt++;
            if (lfsr_step) step_cnt++;
        end
        if (lfsr_step && !busy) check("step_outside_busy", 1, 0);
        if (!rst && ack != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", int'(ack), 0);
            end else begin : pop
                exp_t e;
                e = exp_q.pop_front();
                check("ack_onehot", int'(ack), 1 << e.idx);
                check("rnd_out", int'(rnd_out), e.val);
                check("busy_cycles", busy_cnt, 2 * e.draws + 1);
                check("lfsr_steps", step_cnt, e.draws);
            end
        end
    end

    initial begin
        for (int i = 0; i < WSZ; i++) words[i] = WIDTH'($urandom);
        for (int i = 0; i < NUM_REQ; i++) begin
            rb[i]   = 0;
            rrep[i] = 1;
        end
        // NOTE: stimulus is driven with blocking assignments on the falling edge, away from sampling.
        rst   = 1'b1;
        req   = '0;
        bound = '0;
        repeat (3) @(negedge clk);
        check("reset_ack", int'(ack), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_step", int'(lfsr_step), 0);
        check("reset_rnd_out", int'(rnd_out), 0);
        rst = 1'b0;
        @(negedge clk);

        words[(widx + 1) % WSZ] = 10'h2A5;
        rb[0] = 0;
        run_round(4'b0001);

        words[(widx + 1) % WSZ] = 10'h3F7;
        rb[1] = 10;
        run_round(4'b0010);

        words[(widx + 1) % WSZ] = 10'h3FC;
        words[(widx + 2) % WSZ] = 10'h3FD;
        words[(widx + 3) % WSZ] = 10'h3FF;
        words[(widx + 4) % WSZ] = 10'h3FE;
        rb[2] = 10;
        run_round(4'b0100);

        for (int i = 0; i < NUM_REQ; i++) begin
            rb[i]   = rand_bound();
            rrep[i] = 2;
        end
        run_round(4'b1111);

        for (int r = 0; r < 40; r++) begin
            logic [NUM_REQ-1:0] m;
            m = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            for (int i = 0; i < NUM_REQ; i++) begin
                rb[i]   = rand_bound();
                rrep[i] = int'($urandom_range(1, 2));
            end
            run_round(m);
        end

        // Abort a service while it sits in CHECK.
        bound[0 +: WIDTH] = '0;
        req = 4'b0001;
        @(negedge clk);
        check("abort_draw_step", int'(lfsr_step), 1);
        @(negedge clk);
        check("abort_busy_before", int'(busy), 1);
        rst = 1'b1;
        req = '0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_ack", int'(ack), 0);
        check("abort_step", int'(lfsr_step), 0);
        check("abort_rnd_out", int'(rnd_out), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        model_rr = 0;
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            rb[i]   = rand_bound();
            rrep[i] = 1;
        end
        run_round(4'b0100);
        run_round(4'b0011);

        repeat (2) @(negedge clk);
        check("leftover_expected", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
